// File: rtl/alarm_qsys_timer_pkg.sv
// rtl/alarm_qsys_timer_pkg.sv - register map, bit indices and address decode for the interval timer
package alarm_qsys_timer_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  localparam logic [ADDR_W-1:0] ADDR_STATUS   = 4'd0;
  localparam logic [ADDR_W-1:0] ADDR_CONTROL  = 4'd1;
  localparam logic [ADDR_W-1:0] ADDR_PERIOD0  = 4'd2;
  localparam logic [ADDR_W-1:0] ADDR_SNAP0    = 4'd6;
  localparam logic [ADDR_W-1:0] ADDR_PRESCALE = 4'd10;

  // STATUS bits
  localparam int TO  = 0;
  localparam int RUN = 1;
  // CONTROL bits
  localparam int ITO   = 0;
  localparam int CONT  = 1;
  localparam int START = 2;
  localparam int STOP  = 3;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_STATUS,
    SEL_CONTROL,
    SEL_PERIOD,
    SEL_SNAP,
    SEL_PRESCALE
  } reg_sel_e;

  function automatic reg_sel_e decode_addr(input logic [ADDR_W-1:0] address);
    reg_sel_e sel;
    if (address == ADDR_STATUS)
      sel = SEL_STATUS;
    else if (address == ADDR_CONTROL)
      sel = SEL_CONTROL;
    else if (address >= ADDR_PERIOD0 && address < ADDR_SNAP0)
      sel = SEL_PERIOD;
    else if (address >= ADDR_SNAP0 && address < ADDR_PRESCALE)
      sel = SEL_SNAP;
    else if (address == ADDR_PRESCALE)
      sel = SEL_PRESCALE;
    else
      sel = SEL_NONE;
    return sel;
  endfunction

endpackage

// File: rtl/alarm_qsys_timer_if.sv
// rtl/alarm_qsys_timer_if.sv - 16-bit register bus plus irq between CPU and timer
interface alarm_qsys_timer_if;
  import alarm_qsys_timer_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/alarm_qsys_timer_core.sv
// rtl/alarm_qsys_timer_core.sv - down-counter with reload and zero-entry timeout detect
module alarm_qsys_timer_core #(
  parameter int                   COUNTER_W = 32,
  parameter logic [COUNTER_W-1:0] RESET_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 load,
  input  logic [COUNTER_W-1:0] period,
  output logic [COUNTER_W-1:0] counter,
  output logic                 is_zero,
  output logic                 timeout_event
);

  logic zero_q;

  assign is_zero       = (counter == '0);
  assign timeout_event = is_zero & ~zero_q;

  // zero_q starts as "already zero" when the reset value is 0 so reset itself is not a timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter <= RESET_VAL;
      zero_q  <= (RESET_VAL == '0);
    end else begin
      zero_q <= is_zero;
      if (load)
        counter <= period;
      else if (tick)
        counter <= is_zero ? period : counter - COUNTER_W'(1);
    end
  end

endmodule

// File: rtl/alarm_qsys_timer_param.sv
// rtl/alarm_qsys_timer_param.sv - parametrised interval timer; ALARM_QSYS_TIMER_PRESCALER_EN adds the PRESCALE register
module alarm_qsys_timer_param
  import alarm_qsys_timer_pkg::*;
#(
  parameter int          COUNTER_W    = 32,
  parameter logic [63:0] RESET_PERIOD = 64'd49_999_999
) (
  input  logic                      clk,
  input  logic                      reset_n,
  alarm_qsys_timer_if.slave         bus
);

  localparam logic [COUNTER_W-1:0] RESET_VAL = RESET_PERIOD[COUNTER_W-1:0];

  reg_sel_e              sel;
  logic                  wr;
  logic [1:0]            word_idx;
  logic                  start_wr;
  logic                  stop_wr;
  logic                  tick;
  logic                  force_reload;
  logic                  to_q;
  logic                  run_q;
  logic                  ito_q;
  logic                  cont_q;
  logic [COUNTER_W-1:0]  period_q;
  logic [COUNTER_W-1:0]  snap_q;
  logic [COUNTER_W-1:0]  counter;
  logic                  is_zero;
  logic                  timeout_event;
  logic [63:0]           period_wide;
  logic [63:0]           snap_wide;
  logic [63:0]           period_ext;
  logic [DATA_W-1:0]     rd_mux;

  assign sel      = decode_addr(bus.address);
  assign wr       = bus.chipselect & ~bus.write_n;
  assign word_idx = (sel == SEL_SNAP) ? 2'(bus.address - ADDR_SNAP0)
                                      : 2'(bus.address - ADDR_PERIOD0);
  assign start_wr = wr && (sel == SEL_CONTROL) && bus.writedata[START];
  assign stop_wr  = wr && (sel == SEL_CONTROL) && bus.writedata[STOP];

  // Zero-extending to 64 bits makes bits above COUNTER_W and words past the top read 0 for free
  assign period_wide = 64'(period_q);
  assign snap_wide   = 64'(snap_q);

  always_comb begin
    period_ext = period_wide;
    period_ext[{word_idx, 4'd0} +: DATA_W] = bus.writedata;
  end

`ifdef ALARM_QSYS_TIMER_PRESCALER_EN
  logic [DATA_W-1:0] prescale_q;
  logic [DATA_W-1:0] pre_cnt;

  assign tick = run_q && (pre_cnt == prescale_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescale_q <= '0;
      pre_cnt    <= '0;
    end else begin
      if (wr && sel == SEL_PRESCALE)
        prescale_q <= bus.writedata;
      if (start_wr || force_reload || !run_q || tick)
        pre_cnt <= '0;
      else
        pre_cnt <= pre_cnt + DATA_W'(1);
    end
  end
`else
  assign tick = run_q;
`endif

  alarm_qsys_timer_core #(
    .COUNTER_W (COUNTER_W),
    .RESET_VAL (RESET_VAL)
  ) u_core (
    .clk           (clk),
    .rst_n         (reset_n),
    .tick          (tick),
    .load          (force_reload),
    .period        (period_q),
    .counter       (counter),
    .is_zero       (is_zero),
    .timeout_event (timeout_event)
  );

  always_comb begin
    rd_mux = '0;
    case (sel)
      SEL_STATUS: begin
        rd_mux[TO]  = to_q;
        rd_mux[RUN] = run_q;
      end
      SEL_CONTROL: begin
        rd_mux[ITO]  = ito_q;
        rd_mux[CONT] = cont_q;
      end
      SEL_PERIOD: rd_mux = period_wide[{word_idx, 4'd0} +: DATA_W];
      SEL_SNAP:   rd_mux = snap_wide[{word_idx, 4'd0} +: DATA_W];
`ifdef ALARM_QSYS_TIMER_PRESCALER_EN
      SEL_PRESCALE: rd_mux = prescale_q;
`endif
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_q         <= 1'b0;
      run_q        <= 1'b0;
      ito_q        <= 1'b0;
      cont_q       <= 1'b0;
      force_reload <= 1'b0;
      period_q     <= RESET_VAL;
      snap_q       <= '0;
      bus.readdata <= '0;
    end else begin
      bus.readdata <= rd_mux;
      force_reload <= wr && (sel == SEL_PERIOD);

      if (wr && sel == SEL_CONTROL) begin
        ito_q  <= bus.writedata[ITO];
        cont_q <= bus.writedata[CONT];
      end
      if (wr && sel == SEL_PERIOD)
        period_q <= period_ext[COUNTER_W-1:0];
      if (wr && sel == SEL_SNAP)
        snap_q <= counter;

      // START beats STOP, a pending reload and the one-shot stop
      if (start_wr)
        run_q <= 1'b1;
      else if (stop_wr || force_reload)
        run_q <= 1'b0;
      else if (tick && is_zero && !cont_q)
        run_q <= 1'b0;

      if (wr && sel == SEL_STATUS)
        to_q <= 1'b0;
      else if (timeout_event)
        to_q <= 1'b1;
    end
  end

  assign bus.irq = to_q & ito_q;

endmodule

// File: tb/tb_alarm_qsys_timer_param.sv
// tb/tb_alarm_qsys_timer_param.sv - directed and randomized checks of the interval timer against a timing model
module tb_alarm_qsys_timer_param;
  import alarm_qsys_timer_pkg::*;

  localparam int CW = 48;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  alarm_qsys_timer_if bus();

  alarm_qsys_timer_param #(.COUNTER_W(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int     n_assert = 0;
  int     n_fail   = 0;
  longint edge_cnt = 0;
  longint wr_edge, rd_edge, es;
  longint m_c0, m_p;
  int     m_s = 0;
  bit     m_cont, m_ito, tm;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    bus.address    = '0;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
    wr_edge = edge_cnt + 1;
    @(posedge clk); #1;
    idle();
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [15:0] d);
    @(posedge clk); #1;
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
    rd_edge = edge_cnt + 1;
    @(posedge clk); #1;
    d = bus.readdata;
    idle();
  endtask

  task automatic set_period(input longint p);
    logic [47:0] pv;
    pv = 48'(p);
    bus_write(ADDR_PERIOD0,        pv[15:0]);
    bus_write(ADDR_PERIOD0 + 4'd1, pv[31:16]);
    bus_write(ADDR_PERIOD0 + 4'd2, pv[47:32]);
    m_p = p;
    m_c0 = p;
  endtask

  task automatic start(input logic [15:0] ctrl);
    bus_write(ADDR_STATUS, 16'h0000);
    tm = 1'b0;
    bus_write(ADDR_CONTROL, ctrl);
    es = wr_edge;
    m_cont = ctrl[CONT];
    m_ito  = ctrl[ITO];
  endtask

  task automatic read_snap(output logic [63:0] v);
    logic [15:0] w0, w1, w2;
    bus_read(ADDR_SNAP0,        w0);
    bus_read(ADDR_SNAP0 + 4'd1, w1);
    bus_read(ADDR_SNAP0 + 4'd2, w2);
    v = {16'h0, w2, w1, w0};
  endtask

  // Timeouts land one edge after the counter first reaches 0, then every (P+1) ticks in continuous mode
  function automatic bit event_at(input longint e);
    longint d, q;
    d = e - es - 1;
    if (d < m_c0 * (m_s + 1) || (d % (m_s + 1)) != 0) return 1'b0;
    q = d / (m_s + 1) - m_c0;
    if (q == 0) return 1'b1;
    if (!m_cont || m_p == 0) return 1'b0;
    return (q % (m_p + 1)) == 0;
  endfunction

  function automatic longint cnt_after(input longint c0, input longint p, input bit cont, input longint n);
    if (n <= c0) return c0 - n;
    if (!cont) return p;
    return p - ((n - c0 - 1) % (p + 1));
  endfunction

  task automatic watch(input int n, input int clr_a, input int clr_b);
    longint clr_edge;
    clr_edge = -1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (edge_cnt == clr_edge) tm = 1'b0;
      else if (event_at(edge_cnt)) tm = 1'b1;
      check($sformatf("irq_e%0d", edge_cnt - es), 64'(bus.irq), 64'(tm & m_ito));
      if (i == clr_a || i == clr_b) begin
        bus.address = ADDR_STATUS; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = 16'($urandom);
        clr_edge = edge_cnt + 1;
      end else begin
        idle();
      end
    end
    idle();
  endtask

  logic [15:0] rd;
  logic [15:0] exp_st;
  logic [63:0] v;
  logic [63:0] expv;
  longint      p, t;
  int          nwait;
  bit          rc;

  initial begin
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("reset_readdata", 64'(bus.readdata), 64'h0);
    check("reset_irq", 64'(bus.irq), 64'h0);
    reset_n = 1'b1;

    bus_read(ADDR_STATUS, rd);        check("rst_status", 64'(rd), 64'h0);
    bus_read(ADDR_CONTROL, rd);       check("rst_control", 64'(rd), 64'h0);
    bus_read(ADDR_PERIOD0, rd);       check("rst_period_w0", 64'(rd), 64'hF07F);
    bus_read(ADDR_PERIOD0 + 4'd1, rd); check("rst_period_w1", 64'(rd), 64'h02FA);
    bus_read(ADDR_PERIOD0 + 4'd2, rd); check("rst_period_w2", 64'(rd), 64'h0);
    bus_read(ADDR_SNAP0, rd);         check("rst_snap_w0", 64'(rd), 64'h0);
    check("rst_irq_after", 64'(bus.irq), 64'h0);

    // continuous, period 4, clears after the first timeout and exactly on the third
    set_period(4);
    start(16'h0007);
    watch(22, 5, 13);

    bus_write(ADDR_CONTROL, 16'h0008);
    bus_read(ADDR_STATUS, rd);        check("stop_run", 64'(rd[RUN]), 64'h0);
    bus_read(ADDR_CONTROL, rd);       check("control_strobes_read0", 64'(rd), 64'h0);
    bus_write(ADDR_CONTROL, 16'h000E);
    bus_read(ADDR_STATUS, rd);        check("start_wins_run", 64'(rd[RUN]), 64'h1);
    bus_read(ADDR_CONTROL, rd);       check("control_cont", 64'(rd), 64'h2);
    bus_write(ADDR_PERIOD0, 16'h0009);
    bus_read(ADDR_STATUS, rd);        check("period_wr_stops", 64'(rd[RUN]), 64'h0);
    bus_write(ADDR_SNAP0 + 4'd3, 16'h1234);
    bus_read(ADDR_SNAP0, rd);         check("period_wr_reload", 64'(rd), 64'h9);
    bus_read(ADDR_PERIOD0, rd);       check("period_rd", 64'(rd), 64'h9);

    // one-shot, period 3
    set_period(3);
    start(16'h0005);
    watch(10, -1, -1);
    bus_read(ADDR_STATUS, rd);        check("oneshot_status", 64'(rd), 64'h1);
    bus_write(ADDR_SNAP0, 16'h0000);
    bus_read(ADDR_SNAP0, rd);         check("oneshot_counter", 64'(rd), 64'h3);

    // bits above COUNTER_W and unmapped addresses
    bus_write(ADDR_PERIOD0 + 4'd3, 16'hFFFF);
    bus_read(ADDR_PERIOD0 + 4'd3, rd); check("period_w3_ignored", 64'(rd), 64'h0);
    bus_write(4'd12, 16'hFFFF);
    bus_read(4'd12, rd);              check("unmapped_read0", 64'(rd), 64'h0);

    // 48-bit period with a borrow across word boundaries
    set_period(64'h1_0000_0010);
    start(16'h0004);
    repeat (20) @(posedge clk);
    bus_write(ADDR_SNAP0, 16'h0000);
    expv = 64'(cnt_after(m_c0, m_p, m_cont, wr_edge - 1 - es));
    read_snap(v);
    check("snap48", v, expv);
    check("snap48_below_period", 64'(v < 64'h1_0000_0010), 64'h1);
    bus_read(ADDR_SNAP0 + 4'd3, rd);  check("snap_w3_zero", 64'(rd), 64'h0);
    bus_write(ADDR_CONTROL, 16'h0008);

    for (int it = 0; it < 8; it++) begin
      if (it % 2 == 0) p = longint'($urandom_range(1, 30));
      else p = longint'({16'($urandom), 32'($urandom)}) | 64'd1;
      rc = 1'($urandom_range(0, 1));
      set_period(p);
      start(rc ? 16'h0006 : 16'h0004);
      nwait = int'($urandom_range(0, 60));
      repeat (nwait) @(posedge clk);
      bus_write(4'(ADDR_SNAP0 + 4'($urandom_range(0, 3))), 16'($urandom));
      expv = 64'(cnt_after(m_c0, m_p, m_cont, wr_edge - 1 - es));
      read_snap(v);
      check($sformatf("rand%0d_snap", it), v, expv);
      bus_read(ADDR_STATUS, rd);
      t = rd_edge - 1 - es;
      exp_st = '0;
      exp_st[RUN] = m_cont || (t <= p);
      exp_st[TO]  = (t > p);
      check($sformatf("rand%0d_status", it), 64'(rd), 64'(exp_st));
      bus_write(ADDR_CONTROL, 16'h0008);
    end

`ifdef ALARM_QSYS_TIMER_PRESCALER_EN
    bus_write(ADDR_PRESCALE, 16'h0003);
    bus_read(ADDR_PRESCALE, rd);      check("prescale_rd", 64'(rd), 64'h3);
    m_s = 3;
    set_period(1);
    start(16'h0007);
    watch(24, 5, 13);
    m_s = 0;
    bus_write(ADDR_CONTROL, 16'h0008);
    bus_write(ADDR_PRESCALE, 16'h0000);
`else
    bus_write(ADDR_PRESCALE, 16'h0003);
    bus_read(ADDR_PRESCALE, rd);      check("prescale_absent", 64'(rd), 64'h0);
`endif

    // asynchronous reset while running with irq asserted
    set_period(2);
    start(16'h0007);
    repeat (10) @(posedge clk);
    #1;
    check("pre_reset_irq", 64'(bus.irq), 64'h1);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_irq", 64'(bus.irq), 64'h0);
    check("async_reset_readdata", 64'(bus.readdata), 64'h0);
    #2 reset_n = 1'b1;
    bus_read(ADDR_STATUS, rd);        check("post_reset_status", 64'(rd), 64'h0);
    bus_read(ADDR_PERIOD0, rd);       check("post_reset_period", 64'(rd), 64'hF07F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_qsys_timer_param.md
Name: alarm_qsys_timer_param

Overview:
- Parametrised next-generation Avalon-MM interval timer for the alarm_qsys system; one timer per instance, one irq line to the CPU.
- Counter width is a parameter (17..64 bits). The period is software-writable and readable, instead of fixed at build time.
- Keeps the established status/control/snapshot programming model on a 16-bit bus, with the register map extended for wider counters.

Parameters:
- COUNTER_W, 32, counter/period/snapshot width in bits; legal range 17..64.
- RESET_PERIOD, 50000000-1, period register and counter value after reset; truncated to COUNTER_W.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low.
- address  in  4  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
- writedata  in  16  write data.
- readdata  out  16  registered read data.
- irq  out  1  level interrupt = TO & ITO.

Behaviour:
- Register map:
  - 0 STATUS: bit0 TO (sticky timeout), bit1 RUN.
  - 1 CONTROL: bit0 ITO, bit1 CONT, bit2 START, bit3 STOP.
  - 2..5 PERIOD words 0..3, LSW first.
  - 6..9 SNAP words 0..3, LSW first.
  - 10 PRESCALE (optional feature only).
  - Other addresses read 0; writes to them are ignored.
- Word k of PERIOD/SNAP covers bits [16k+15:16k]. Bits at or above COUNTER_W are write-ignored and read 0. Words beyond ceil(COUNTER_W/16) read 0.
- Reset values:
  - readdata=0, irq=0, TO=0, RUN=0, ITO=CONT=0.
  - period=RESET_PERIOD, counter=RESET_PERIOD, snapshot=0.
- Reads: readdata is updated every cycle from the mux on address; data is valid the cycle after address is presented (1-cycle latency). Reads have no side effects.
- CONTROL write:
  - ITO and CONT are stored.
  - START and STOP are strobes only; they read back 0.
  - START=1: RUN<=1 next cycle, with no reload (resume from current count).
  - STOP=1 with START=0: RUN<=0.
  - START and STOP both 1: START wins.
- STATUS write, any data: TO<=0. A simultaneous timeout event loses, so TO ends 0.
- PERIOD write:
  - The addressed word updates.
  - Next cycle: force_reload, so counter<=period (new value), and RUN<=0.
  - Software must set START again to run.
  - Writing the LSW and MSW in consecutive cycles is legal; each write reloads.
- Counting: on each tick (every clk without the optional feature) while RUN=1:
  - counter!=0: counter decrements by 1.
  - counter==0: counter<=period. If CONT=0, RUN<=0.
  - Timeout interval is therefore period+1 ticks.
- Timeout event: the cycle in which the counter is 0 and it was not 0 the previous cycle → TO<=1.
  - Period=0 in continuous mode holds the counter at 0, so only one event occurs until the counter leaves 0.
- Snapshot: a write of any data to any of addresses 6..9 copies the current counter into the snapshot register. Reads of 6..9 return the latched words, so a multi-word read is coherent.
- Counter arithmetic is modulo 2^COUNTER_W. Decrement never goes below 0, because 0 always triggers a reload.
- Asynchronous reset mid-count returns every register to its reset value immediately; no pending strobe survives.

Optional Feature:
- Macro ALARM_QSYS_TIMER_PRESCALER_EN.
- Defined:
  - Adds a 16-bit PRESCALE register at address 10, reset 0, readable and writable.
  - An internal prescale counter generates a tick every PRESCALE+1 clocks while RUN=1.
  - The prescale counter clears on START, force_reload and when RUN=0.
  - The timer decrements only on ticks.
- Undefined: tick=1 every clock; address 10 reads 0 and writes are ignored.

Decomposition:
- Package alarm_qsys_timer_pkg holds:
  - Address constants: ADDR_STATUS, ADDR_CONTROL, ADDR_PERIOD0, ADDR_SNAP0, ADDR_PRESCALE.
  - Bit indices: TO, RUN, ITO, CONT, START, STOP.
  - Bus width constant DATA_W=16.
- One sub-module, alarm_qsys_timer_core:
  - Inputs: tick, load, period.
  - Outputs: counter, is_zero, timeout_event.
  - It holds the counter, the zero-edge detect and the reload logic.
- The top level holds register decode, RUN/TO, snapshot, the read mux and the prescaler.

Test Plan:
- Reset, then read 0, 1, 2, 3 → 0x0000, 0x0000, 0xF07F, 0x02FA; irq=0.
- Write PERIOD=0x0004, write CONTROL=0x0007 (START|CONT|ITO) → TO rises every 5 clocks; irq high from the first event; STATUS write clears irq in the next cycle and it re-asserts on the next timeout.
- One-shot: PERIOD=3, CONTROL=0x0004 → exactly one TO after 4 clocks, then RUN=0; the counter stays at period=3.
- COUNTER_W=48: write words 0..2 = 0x0010, 0x0000, 0x0001 and start; snapshot write at address 6, then read 6/7/8 → coherent 48-bit value below 0x1_0000_0010; word 3 reads 0.
- Same-cycle conflicts: STATUS write in the timeout cycle → TO stays 0; CONTROL=0x000C → RUN=1; PERIOD write while running → RUN=0 and counter=new period.
- With ALARM_QSYS_TIMER_PRESCALER_EN: PRESCALE=3, PERIOD=1, continuous → timeout every 8 clocks; address 10 reads 0x0003.
